indicator_pos_ctrl: RTL and testbench
=====================================

Name: indicator_pos_ctrl

Overview:
- Frame-synchronous controller that owns the x_pos/y_pos inputs of the 16x16 box detector (pulse_indicator) in the 640x480 character/HDMI pipeline.
- Latches single-cycle move/home/event pulses at any time, applies them once per frame at the start of vertical blank (no mid-frame tearing), and generates a frame-counted flash enable.
- Sits between the button/pulse front end and the box detector; consumes the VGA h/v counters.

Parameters:
- H_START, 144, first active pixel column (h_val).
- V_START, 35, first active line (v_val).
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines.
- BOX, 16, box size and move step in pixels.
- FLASH_FRAMES, 30, frames flash_on stays high after event_pulse; max 63.

Ports:
- clk  in  1  pixel clock; h_val advances once per clk.
- rst  in  1  synchronous, active-low reset.
- h_val  in  10  horizontal counter, 0..799.
- v_val  in  10  vertical counter, 0..524.
- move_left  in  1  single-cycle request, x -= BOX.
- move_right  in  1  single-cycle request, x += BOX.
- move_up  in  1  single-cycle request, y -= BOX.
- move_down  in  1  single-cycle request, y += BOX.
- home  in  1  single-cycle request, return to (H_START, V_START).
- event_pulse  in  1  single-cycle event; (re)starts the flash.
- x_pos  out  10  box left edge; to pulse_indicator.
- y_pos  out  10  box top edge; to pulse_indicator.
- flash_on  out  1  high while the flash frame counter is nonzero.
- frame_tick  out  1  registered one-cycle pulse, once per frame.
- busy  out  1  high while any request is pending (state PEND).

Behaviour:
- Reset (rst==0 at a clk edge): x_pos=144, y_pos=35, flash_on=0, frame_tick=0, busy=0, pending flags cleared, flash counter=0, state IDLE.
- Tick condition: tick_c = (h_val==0 && v_val==V_START+V_ACTIVE), i.e. 515. It is true for exactly one clk per frame. frame_tick = tick_c registered (1-cycle delay).
- Pending flags pl, pr, pu, pd, ph. Each clk, flag <= flag | corresponding input. Flags clear on the tick edge.
- Apply: on the edge where tick_c==1, the effective request eff = flags | inputs in that same cycle. A pulse coincident with the tick is applied now, not deferred.
  - New x_pos/y_pos are visible the cycle after the tick, together with frame_tick.
- Apply priority:
  - eff home overrides all moves: x=144, y=35.
  - Otherwise eff left and right both set: no x change. Same rule for up and down.
  - Moves along x and y are independent; a diagonal applies both.
- Clamp, no wrap:
  - x range 144..768 (H_START+H_ACTIVE-BOX). Right at 768 holds 768; left at 144 holds 144.
  - y range 35..499 (V_START+V_ACTIVE-BOX). Down at 499 holds; up at 35 holds.
  - Compute in 11 bits before compare so no 10-bit overflow is possible.
- Multiple pulses of the same direction between ticks collapse to one step per frame.
- FSM, 2 states:
  - IDLE -> PEND when any move/home input is high and tick_c==0.
  - PEND -> IDLE on tick_c.
  - IDLE with input and tick_c both high: apply immediately, stay IDLE.
  - busy = (state==PEND).
- Flash counter (6 bits):
  - event_pulse loads FLASH_FRAMES immediately (next edge), including when the counter is already nonzero (retrigger).
  - Otherwise it decrements by 1 on each tick edge when nonzero.
  - event_pulse and tick_c in the same cycle: load wins.
  - flash_on = (count != 0), registered with the counter.
- Reset mid-PEND discards pending requests; position returns to home.
- Outputs x_pos/y_pos never change except on a tick edge or reset.

Decomposition:
- Package vga_timing_pkg:
  - Constants H_TOTAL=800, V_TOTAL=525, H_START=144, V_START=35, H_ACTIVE=640, V_ACTIVE=480, BOX=16.
  - Derived X_MAX=768, Y_MAX=499, TICK_LINE=515.
  - State encoding localparams S_IDLE=0, S_PEND=1.
- One sub-module, frame_tick_gen: compares h_val/v_val against TICK_LINE and outputs tick_c plus the registered frame_tick. It is reusable by other frame-synchronous blocks.
- pulse_indicator is instantiated at the top level, not inside this block.

Test Plan:
- Reset with rst=0 for 3 clks -> x_pos=144, y_pos=35, flash_on=0, busy=0. Run a full frame -> frame_tick exactly one cycle, the cycle after h_val=0, v_val=515.
- move_right at h=300, v=100 -> busy=1; x_pos stays 144 until the tick, then 160. Pulse move_right 3 times in one frame -> x_pos advances only 16.
- Preload x=768, y=499 via repeated moves; then move_right+move_down -> stays 768/499. From home, move_left+move_up -> stays 144/35.
- move_left+move_right in the same frame -> x unchanged. move_down coincident with the tick cycle -> applied at that tick, busy never asserts.
- home plus move_right at x=400 -> x=144, y=35 after the tick.
- event_pulse -> flash_on=1 for exactly 30 frame_ticks. Retrigger at tick 20 -> stays high 30 more ticks. Reset asserted while busy=1 -> pending move dropped, x=144 after the next frame.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Purpose: shared 640x480 VGA timing constants, box geometry, the request
//          bundle type and the controller state encoding used by the
//          frame-synchronous indicator blocks.
// Ports:   none (package).
package vga_timing_pkg;

  localparam int H_TOTAL   = 800;
  localparam int V_TOTAL   = 525;
  localparam int H_START   = 144;
  localparam int V_START   = 35;
  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int BOX       = 16;

  localparam int X_MAX     = H_START + H_ACTIVE - BOX;  // 768
  localparam int Y_MAX     = V_START + V_ACTIVE - BOX;  // 499
  localparam int TICK_LINE = V_START + V_ACTIVE;        // 515, first blank line

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } state_t;

  typedef struct packed {
    logic home;
    logic left;
    logic right;
    logic up;
    logic down;
  } req_t;

  // One BOX step along an axis, clamped to [lo, hi]. Opposing requests
  // cancel. Done in 11 bits so pos + BOX can never wrap.
  function automatic logic [9:0] step_clamp(
    input logic [9:0]  pos,
    input logic        dec,
    input logic        inc,
    input logic [10:0] lo,
    input logic [10:0] hi
  );
    logic [10:0] wide;
    logic [10:0] moved;
    wide       = {1'b0, pos};
    moved      = wide;
    step_clamp = pos;
    if (dec && !inc) begin
      if (wide < lo + 11'(BOX)) step_clamp = lo[9:0];
      else begin
        moved      = wide - 11'(BOX);
        step_clamp = moved[9:0];
      end
    end else if (inc && !dec) begin
      moved = wide + 11'(BOX);
      if (moved > hi) step_clamp = hi[9:0];
      else            step_clamp = moved[9:0];
    end
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Purpose: detects the first pixel of vertical blank and produces a
//          combinational tick plus a registered one-cycle frame pulse.
// Ports:
//   clk        in  pixel clock
//   rst        in  synchronous active-low reset
//   h_val      in  horizontal counter 0..799
//   v_val      in  vertical counter 0..524
//   tick_c     out high for the single clk where h=0, v=TICK_LINE
//   frame_tick out tick_c delayed by one clk
module frame_tick_gen
  import vga_timing_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] h_val,
  input  logic [9:0] v_val,
  output logic       tick_c,
  output logic       frame_tick
);

  logic frame_tick_reg;

  assign tick_c     = (h_val == 10'd0) && (v_val == 10'(TICK_LINE));
  assign frame_tick = frame_tick_reg;

  always_ff @(posedge clk) begin
    if (!rst) frame_tick_reg <= 1'b0;
    else      frame_tick_reg <= tick_c;
  end

endmodule

// File: rtl/indicator_pos_ctrl.sv
// Purpose: owns the box detector's x/y position. Move/home pulses are
//          latched at any time and applied once per frame at the start of
//          vertical blank, so the box never tears mid-frame. Also runs a
//          frame-counted flash enable started by event_pulse.
// Ports:
//   clk         in  pixel clock
//   rst         in  synchronous active-low reset
//   h_val/v_val in  VGA counters
//   move_*      in  single-cycle step requests (BOX pixels)
//   home        in  single-cycle request to return to (H_START, V_START)
//   event_pulse in  (re)starts the flash
//   x_pos/y_pos out box top-left corner
//   flash_on    out high while the flash frame counter is nonzero
//   frame_tick  out one-cycle pulse per frame, aligned with position update
//   busy        out a request is waiting for the next frame tick
module indicator_pos_ctrl
  import vga_timing_pkg::*;
#(
  parameter int FLASH_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] h_val,
  input  logic [9:0] v_val,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       move_up,
  input  logic       move_down,
  input  logic       home,
  input  logic       event_pulse,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       flash_on,
  output logic       frame_tick,
  output logic       busy
);

  localparam logic [5:0] FLASH_LOAD = 6'(FLASH_FRAMES);

  logic       tick_c;
  req_t       req_in;
  req_t       eff;
  req_t       pend_reg,  pend_next;
  state_t     state_reg, state_next;
  logic [9:0] x_reg,     x_next;
  logic [9:0] y_reg,     y_next;
  logic [5:0] cnt_reg,   cnt_next;
  logic       flash_reg;

  frame_tick_gen u_tick (
    .clk        (clk),
    .rst        (rst),
    .h_val      (h_val),
    .v_val      (v_val),
    .tick_c     (tick_c),
    .frame_tick (frame_tick)
  );

  assign req_in = '{home: home, left: move_left, right: move_right,
                    up: move_up, down: move_down};
  // Requests arriving in the tick cycle itself are applied immediately.
  assign eff    = req_t'(pend_reg | req_in);

  always_comb begin
    state_next = state_reg;
    pend_next  = req_t'(pend_reg | req_in);
    x_next     = x_reg;
    y_next     = y_reg;
    cnt_next   = cnt_reg;

    case (state_reg)
      S_IDLE:  if ((|req_in) && !tick_c) state_next = S_PEND;
      S_PEND:  if (tick_c) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    if (tick_c) begin
      pend_next = '0;
      if (eff.home) begin
        x_next = 10'(H_START);
        y_next = 10'(V_START);
      end else begin
        x_next = step_clamp(x_reg, eff.left, eff.right, 11'(H_START), 11'(X_MAX));
        y_next = step_clamp(y_reg, eff.up,   eff.down,  11'(V_START), 11'(Y_MAX));
      end
    end

    // A load coincident with a tick wins over that tick's decrement.
    if (event_pulse)                      cnt_next = FLASH_LOAD;
    else if (tick_c && cnt_reg != 6'd0)   cnt_next = cnt_reg - 6'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      pend_reg  <= '0;
      x_reg     <= 10'(H_START);
      y_reg     <= 10'(V_START);
      cnt_reg   <= 6'd0;
      flash_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      cnt_reg   <= cnt_next;
      flash_reg <= (cnt_next != 6'd0);
    end
  end

  assign x_pos    = x_reg;
  assign y_pos    = y_reg;
  assign flash_on = flash_reg;
  assign busy     = (state_reg == S_PEND);

endmodule

// File: tb/tb_indicator_pos_ctrl.sv
// Self-checking bench for indicator_pos_ctrl. Frames are compressed: a few
// random non-tick (h,v) cycles followed by the single tick cycle (0,515).
module tb_indicator_pos_ctrl;

  localparam int FLASH = 30;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] h_val, v_val;
  logic       move_left, move_right, move_up, move_down, home, event_pulse;
  logic [9:0] x_pos, y_pos;
  logic       flash_on, frame_tick, busy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_x, m_y, m_cnt;
  bit m_l, m_r, m_u, m_d, m_h, m_tick;

  always #5 clk = ~clk;

  indicator_pos_ctrl #(.FLASH_FRAMES(FLASH)) dut (
    .clk         (clk),
    .rst         (rst),
    .h_val       (h_val),
    .v_val       (v_val),
    .move_left   (move_left),
    .move_right  (move_right),
    .move_up     (move_up),
    .move_down   (move_down),
    .home        (home),
    .event_pulse (event_pulse),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .flash_on    (flash_on),
    .frame_tick  (frame_tick),
    .busy        (busy)
  );

  function automatic bit m_busy();
    return m_l | m_r | m_u | m_d | m_h;
  endfunction

  // One clock: drive on negedge, update model at posedge, return 1ns later.
  task automatic cycle(input bit rs, input int h, input int v,
                       input bit l, input bit r, input bit u, input bit d,
                       input bit hm, input bit ev);
    bit tk, el, er, eu, ed;
    @(negedge clk);
    rst = rs; h_val = 10'(h); v_val = 10'(v);
    move_left = l; move_right = r; move_up = u; move_down = d;
    home = hm; event_pulse = ev;
    @(posedge clk);
    if (!rs) begin
      m_x = 144; m_y = 35; m_cnt = 0; m_tick = 0;
      m_l = 0; m_r = 0; m_u = 0; m_d = 0; m_h = 0;
    end else begin
      tk = (h == 0 && v == 515);
      if (tk) begin
        el = m_l | l; er = m_r | r; eu = m_u | u; ed = m_d | d;
        if (m_h | hm) begin
          m_x = 144; m_y = 35;
        end else begin
          if (el && !er) m_x = (m_x - 16 < 144) ? 144 : m_x - 16;
          if (er && !el) m_x = (m_x + 16 > 768) ? 768 : m_x + 16;
          if (eu && !ed) m_y = (m_y - 16 < 35)  ? 35  : m_y - 16;
          if (ed && !eu) m_y = (m_y + 16 > 499) ? 499 : m_y + 16;
        end
        m_l = 0; m_r = 0; m_u = 0; m_d = 0; m_h = 0;
      end else begin
        m_l |= l; m_r |= r; m_u |= u; m_d |= d; m_h |= hm;
      end
      m_tick = tk;
      if (ev) m_cnt = FLASH;
      else if (tk && m_cnt > 0) m_cnt--;
    end
    #1;
  endtask

  task automatic rand_hv(output int h, output int v);
    h = int'($urandom_range(0, 799));
    v = int'($urandom_range(0, 524));
    if (h == 0 && v == 515) h = 1;
  endtask

  task automatic quiet(input int n);
    int h, v;
    repeat (n) begin
      rand_hv(h, v);
      cycle(1, h, v, 0, 0, 0, 0, 0, 0);
    end
  endtask

  // Frame with one request cycle, some quiet cycles, then the tick cycle.
  task automatic frame_req(input bit l, input bit r, input bit u, input bit d, input bit hm);
    int h, v;
    rand_hv(h, v);
    cycle(1, h, v, l, r, u, d, hm, 0);
    quiet(3);
    cycle(1, 0, 515, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    repeat (3) cycle(0, 300, 100, 1, 1, 1, 1, 1, 1);
    n_cmp++;
    if ({x_pos, y_pos, flash_on, busy, frame_tick} !== {10'd144, 10'd35, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL reset x=%0d y=%0d fl=%0b busy=%0b ft=%0b want 144 35 0 0 0",
               x_pos, y_pos, flash_on, busy, frame_tick);
      n_err++;
    end
    cycle(1, 10, 10, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_frame_tick();
    int hs[5] = '{0, 1, 799, 0, 0};
    int vs[5] = '{514, 515, 515, 516, 0};
    int seen;
    for (int i = 0; i < 5; i++) begin
      cycle(1, hs[i], vs[i], 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (frame_tick !== 1'b0) begin
        $display("FAIL near_miss_tick h=%0d v=%0d frame_tick=%0b want 0", hs[i], vs[i], frame_tick);
        n_err++;
      end
    end
    cycle(1, 0, 515, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (frame_tick !== 1'b1) begin
      $display("FAIL tick_latency frame_tick=%0b want 1", frame_tick);
      n_err++;
    end
    seen = (frame_tick === 1'b1) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      quiet(1);
      if (frame_tick === 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 1) begin
      $display("FAIL tick_width ticks=%0d want 1", seen);
      n_err++;
    end
  endtask

  task automatic test_move_right();
    cycle(1, 300, 100, 0, 1, 0, 0, 0, 0);
    n_cmp++;
    if ({busy, x_pos} !== {1'b1, 10'd144}) begin
      $display("FAIL right_pending busy=%0b x=%0d want 1 144", busy, x_pos);
      n_err++;
    end
    quiet(5);
    n_cmp++;
    if ({busy, x_pos} !== {1'b1, 10'd144}) begin
      $display("FAIL right_hold busy=%0b x=%0d want 1 144", busy, x_pos);
      n_err++;
    end
    cycle(1, 0, 515, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({busy, x_pos, frame_tick} !== {1'b0, 10'd160, 1'b1}) begin
      $display("FAIL right_apply busy=%0b x=%0d ft=%0b want 0 160 1", busy, x_pos, frame_tick);
      n_err++;
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1, 200 + i, 50, 0, 1, 0, 0, 0, 0);
      quiet(2);
    end
    cycle(1, 0, 515, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (x_pos !== 10'd176) begin
      $display("FAIL right_collapse x=%0d want 176", x_pos);
      n_err++;
    end
  endtask

  task automatic test_clamp();
    frame_req(0, 0, 0, 0, 1);
    for (int i = 0; i < 45; i++) frame_req(0, 1, 0, 1, 0);
    n_cmp++;
    if ({x_pos, y_pos} !== {10'd768, 10'd499}) begin
      $display("FAIL clamp_max x=%0d y=%0d want 768 499", x_pos, y_pos);
      n_err++;
    end
    frame_req(0, 1, 0, 1, 0);
    n_cmp++;
    if ({x_pos, y_pos} !== {10'd768, 10'd499}) begin
      $display("FAIL clamp_max_hold x=%0d y=%0d want 768 499", x_pos, y_pos);
      n_err++;
    end
    frame_req(0, 0, 0, 0, 1);
    frame_req(1, 0, 1, 0, 0);
    n_cmp++;
    if ({x_pos, y_pos} !== {10'd144, 10'd35}) begin
      $display("FAIL clamp_min_hold x=%0d y=%0d want 144 35", x_pos, y_pos);
      n_err++;
    end
  endtask

  task automatic test_conflict();
    frame_req(0, 1, 0, 0, 0);  // x = 160, y = 35
    cycle(1, 400, 200, 1, 0, 0, 1, 0, 0);
    cycle(1, 401, 200, 0, 1, 1, 0, 0, 0);
    cycle(1, 0, 515, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({x_pos, y_pos} !== {10'd160, 10'd35}) begin
      $display("FAIL opposing_cancel x=%0d y=%0d want 160 35", x_pos, y_pos);
      n_err++;
    end
    quiet(3);
    cycle(1, 0, 515, 0, 0, 0, 1, 0, 0);
    n_cmp++;
    if ({busy, y_pos} !== {1'b0, 10'd51}) begin
      $display("FAIL down_on_tick busy=%0b y=%0d want 0 51", busy, y_pos);
      n_err++;
    end
  endtask

  task automatic test_home();
    frame_req(0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) frame_req(0, 1, 0, 1, 0);
    n_cmp++;
    if (x_pos !== 10'd400) begin
      $display("FAIL preload_400 x=%0d want 400", x_pos);
      n_err++;
    end
    cycle(1, 500, 300, 0, 0, 0, 0, 1, 0);
    cycle(1, 501, 300, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 515, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({x_pos, y_pos} !== {10'd144, 10'd35}) begin
      $display("FAIL home_priority x=%0d y=%0d want 144 35", x_pos, y_pos);
      n_err++;
    end
  endtask

  task automatic test_flash();
    int ticks;
    cycle(1, 600, 400, 0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (flash_on !== 1'b1) begin
      $display("FAIL flash_start flash_on=%0b want 1", flash_on);
      n_err++;
    end
    ticks = 100;
    for (int i = 1; i <= 100; i++) begin
      frame_req(0, 0, 0, 0, 0);
      if (flash_on !== 1'b1) begin ticks = i; break; end
    end
    n_cmp++;
    if (ticks != FLASH) begin
      $display("FAIL flash_length ticks=%0d want %0d", ticks, FLASH);
      n_err++;
    end
    cycle(1, 600, 400, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 19; i++) frame_req(0, 0, 0, 0, 0);
    quiet(2);
    cycle(1, 0, 515, 0, 0, 0, 0, 0, 1);  // 20th tick carries the retrigger
    ticks = 100;
    for (int i = 1; i <= 100; i++) begin
      frame_req(0, 0, 0, 0, 0);
      if (flash_on !== 1'b1) begin ticks = i; break; end
    end
    n_cmp++;
    if (ticks != FLASH) begin
      $display("FAIL flash_retrigger ticks=%0d want %0d", ticks, FLASH);
      n_err++;
    end
  endtask

  task automatic test_reset_pend();
    frame_req(0, 0, 0, 0, 1);
    frame_req(0, 1, 0, 0, 0);
    cycle(1, 250, 250, 0, 1, 0, 0, 0, 0);
    n_cmp++;
    if ({busy, x_pos} !== {1'b1, 10'd160}) begin
      $display("FAIL pend_before_reset busy=%0b x=%0d want 1 160", busy, x_pos);
      n_err++;
    end
    cycle(0, 251, 250, 0, 0, 0, 0, 0, 0);
    quiet(2);
    cycle(1, 0, 515, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({busy, x_pos} !== {1'b0, 10'd144}) begin
      $display("FAIL reset_drops_pend busy=%0b x=%0d want 0 144", busy, x_pos);
      n_err++;
    end
  endtask

  task automatic test_random();
    int len, h, v;
    bit rs;
    for (int f = 0; f < 80; f++) begin
      len = int'($urandom_range(3, 10));
      for (int c = 0; c <= len; c++) begin
        if (c == len) begin h = 0; v = 515; end
        else rand_hv(h, v);
        rs = ($urandom_range(0, 149) != 0);
        cycle(rs, h, v,
              $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 24) == 0, $urandom_range(0, 39) == 0);
        n_cmp++;
        if ({x_pos, y_pos, flash_on, busy, frame_tick} !==
            {10'(m_x), 10'(m_y), (m_cnt != 0), m_busy(), m_tick}) begin
          $display("FAIL random f=%0d c=%0d got x=%0d y=%0d fl=%0b b=%0b ft=%0b want x=%0d y=%0d fl=%0b b=%0b ft=%0b",
                   f, c, x_pos, y_pos, flash_on, busy, frame_tick,
                   m_x, m_y, (m_cnt != 0), m_busy(), m_tick);
          n_err++;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; h_val = '0; v_val = '0;
    move_left = 0; move_right = 0; move_up = 0; move_down = 0;
    home = 0; event_pulse = 0;
    test_reset();
    test_frame_tick();
    test_move_right();
    test_clamp();
    test_conflict();
    test_home();
    test_flash();
    test_reset_pend();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
